// File: rtl/datapath_pkg.sv
// Shared datapath types and constants for the LEGv8 single-cycle core.
package datapath_pkg;

  parameter int unsigned N       = 64;
  parameter int unsigned REG_CNT = 32;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef logic [4:0]   reg_addr_t;
  typedef logic [N-1:0] word_t;

endpackage

// File: rtl/regfile_wdec.sv
// 5-to-REG_CNT one-hot write decoder; the XZR line is never enabled.
module regfile_wdec
  import datapath_pkg::*;
#(
  parameter int unsigned REG_CNT = datapath_pkg::REG_CNT
) (
  input  logic               we,
  input  logic [4:0]         wa,
  output logic [REG_CNT-1:0] wen
);

  always_comb begin
    wen = '0;
    for (int unsigned i = 0; i < REG_CNT - 1; i++) begin
      wen[i] = we && (wa == 5'(i));
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x N LEGv8 register file: two combinational reads, one clocked write, X31 = XZR.
// Optional same-cycle write-through selected by `define REGFILE_WRITE_BYPASS_EN.
module regfile #(
  parameter int unsigned N       = datapath_pkg::N,
  parameter int unsigned REG_CNT = datapath_pkg::REG_CNT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  input  logic [4:0]   wa3,
  input  logic         we3,
  input  logic [N-1:0] wd3,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2
);

  import datapath_pkg::*;

  logic [REG_CNT-1:0] wen;
  logic [N-1:0]       regs_q [REG_CNT-1];
  logic [N-1:0]       regs_d [REG_CNT-1];

  regfile_wdec #(.REG_CNT(REG_CNT)) u_wdec (
    .we  (we3),
    .wa  (wa3),
    .wen (wen)
  );

  always_comb begin
    for (int unsigned i = 0; i < REG_CNT - 1; i++) begin
      regs_d[i] = wen[i] ? wd3 : regs_q[i];
    end
  end

  // Reset preloads X[i] = i so test programs start from a traceable state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_CNT - 1; i++) begin
        regs_q[i] <= N'(i);
      end
    end else begin
      for (int unsigned i = 0; i < REG_CNT - 1; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  function automatic logic [N-1:0] read_port(input logic [4:0] ra);
    logic [N-1:0] val;
    val = '0;
    if (32'(ra) < REG_CNT - 1) begin
      val = regs_q[ra];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    // Gated by reset so the preload values remain visible while reset is held.
    if (reset && we3 && (wa3 == ra) && (ra != XZR_IDX)) begin
      val = wd3;
    end
`endif
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  we3_known_a: assert property (@(posedge clk) disable iff (!reset) !$isunknown(we3))
    else $error("regfile: we3 is X/Z while reset is deasserted");

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile (either build of REGFILE_WRITE_BYPASS_EN).
module tb_regfile;

  localparam int unsigned N = 64;

  logic         clk;
  logic         reset;
  logic [4:0]   ra1, ra2, wa3;
  logic         we3;
  logic [N-1:0] wd3;
  logic [N-1:0] rd1, rd2;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  regfile #(.N(N), .REG_CNT(32)) dut (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .we3   (we3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] hazard_exp;

  initial begin
    reset = 1'b1;
    we3   = 1'b0;
    wa3   = '0;
    wd3   = '0;
    ra1   = 5'd5;
    ra2   = 5'd30;

    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    chk("rst_rd1_x5",  rd1, 64'd5);
    chk("rst_rd2_x30", rd2, 64'd30);
    ra1 = 5'd31;
    #1;
    chk("rst_rd1_xzr", rd1, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Write and read back
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd9; wd3 = 64'hDEAD_BEEF_0123_4567;
    tick();
    we3 = 1'b0;
    ra1 = 5'd9; ra2 = 5'd10;
    #1;
    chk("wr_rd1_x9",  rd1, 64'hDEAD_BEEF_0123_4567);
    chk("wr_rd2_x10", rd2, 64'd10);
    ra2 = 5'd9;
    #1;
    chk("same_addr_rd2", rd2, 64'hDEAD_BEEF_0123_4567);

    // XZR discard
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd31; wd3 = '1;
    ra1 = 5'd31; ra2 = 5'd31;
    #1;
    chk("xzr_pre_rd1", rd1, 64'd0);
    tick();
    we3 = 1'b0;
    #1;
    chk("xzr_rd1", rd1, 64'd0);
    chk("xzr_rd2", rd2, 64'd0);
    ra1 = 5'd30;
    #1;
    chk("xzr_x30", rd1, 64'd30);

    // Disabled write
    @(negedge clk);
    we3 = 1'b0; wa3 = 5'd4; wd3 = 64'h1234;
    tick();
    ra1 = 5'd4;
    #1;
    chk("we0_x4", rd1, 64'd4);

    // Same-cycle read/write hazard
    @(negedge clk);
`ifdef REGFILE_WRITE_BYPASS_EN
    hazard_exp = 64'hAA;
`else
    hazard_exp = 64'd7;
`endif
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hAA; ra1 = 5'd7;
    #1;
    chk("hazard_pre", rd1, hazard_exp);
    tick();
    we3 = 1'b0;
    #1;
    chk("hazard_post", rd1, 64'hAA);

    // Reset mid-operation
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h55;
    tick();
    we3 = 1'b0; ra1 = 5'd3; ra2 = 5'd9;
    #1;
    chk("x3_written", rd1, 64'h55);
    #2 reset = 1'b0;
    #1;
    chk("midrst_x3", rd1, 64'd3);
    chk("midrst_x9", rd2, 64'd9);
    // A write presented while reset is held must be lost
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h77;
    #1;
    chk("rst_hold_rd", rd1, 64'd3);
    tick();
    we3 = 1'b0;
    #1;
    chk("rst_wr_lost", rd1, 64'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("release_x3", rd1, 64'd3);
    tick();
    chk("release_edge_x3", rd1, 64'd3);
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h99;
    tick();
    we3 = 1'b0;
    #1;
    chk("resume_x3", rd1, 64'h99);
    chk("resume_x9", rd2, 64'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
